nonce_search_ctrl: RTL and testbench

- Initiator-side controller that drives nonce candidates to an external hash unit and compares each returned 8-bit hash against a latched difficulty target.
- Uses a valid/ready request channel and a valid-only response channel.
- Stops on the first hash strictly below the target, or when the nonce range is exhausted.
- Sits between the top-level mining control and the hash core. The unsigned compare is done in-block.

---
 rtl/nonce_search_ctrl.sv | 126 ++++++++++++
 tb/tb_nonce_search_ctrl.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/nonce_search_ctrl.sv
// Nonce search controller: issues nonce candidates to an external hash unit and
// stops on the first returned hash strictly below the latched target, or after MAX_NONCE.
module nonce_search_ctrl #(
  parameter int HASH_W    = 8,
  parameter int NONCE_W   = 4,
  parameter int MAX_NONCE = 15
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_start,
  input  logic               i_abort,
  input  logic [HASH_W-1:0]  i_target,
  output logic               o_req_valid,
  output logic [NONCE_W-1:0] o_req_nonce,
  input  logic               i_req_ready,
  input  logic               i_rsp_valid,
  input  logic [HASH_W-1:0]  i_rsp_hash,
  output logic               o_busy,
  output logic               o_done,
  output logic               o_found,
  output logic [NONCE_W-1:0] o_result_nonce,
  output logic [NONCE_W:0]   o_attempts,
  output logic [1:0]         o_state
);

  // Request channel: a transfer happens on a rising edge where o_req_valid && i_req_ready;
  // o_req_valid/o_req_nonce stay stable until then. Response channel is valid-only, one cycle.

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [NONCE_W-1:0] LAST_NONCE = NONCE_W'(MAX_NONCE);

  state_t             r_state;
  state_t             w_next;
  logic [HASH_W-1:0]  r_target;
  logic [NONCE_W-1:0] r_nonce;
  logic               r_req_valid;
  logic               r_busy;
  logic               r_done;
  logic               r_found;
  logic [NONCE_W-1:0] r_result_nonce;
  logic [NONCE_W:0]   r_attempts;
  logic               w_hit;
  logic               w_last;

  assign w_hit  = (i_rsp_hash < r_target);
  assign w_last = (r_nonce == LAST_NONCE);

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (i_start) w_next = S_ISSUE;
      S_ISSUE: begin
        if (i_abort)          w_next = S_IDLE;
        else if (i_req_ready) w_next = S_WAIT;
      end
      S_WAIT: begin
        if (i_abort)               w_next = S_IDLE;
        else if (i_rsp_valid) begin
          if (w_hit || w_last)     w_next = S_DONE;
          else                     w_next = S_ISSUE;
        end
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Status outputs are flopped from the next state so they line up with r_state.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= S_IDLE;
      r_target       <= '0;
      r_nonce        <= '0;
      r_req_valid    <= 1'b0;
      r_busy         <= 1'b0;
      r_done         <= 1'b0;
      r_found        <= 1'b0;
      r_result_nonce <= '0;
      r_attempts     <= '0;
    end else begin
      r_state     <= w_next;
      r_req_valid <= (w_next == S_ISSUE);
      r_busy      <= (w_next == S_ISSUE) || (w_next == S_WAIT);
      r_done      <= (w_next == S_DONE);
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_target       <= i_target;
            r_nonce        <= '0;
            r_attempts     <= '0;
            r_found        <= 1'b0;
            r_result_nonce <= '0;
          end
        end
        S_WAIT: begin
          if (!i_abort && i_rsp_valid) begin
            r_attempts <= r_attempts + (NONCE_W+1)'(1);
            if (w_hit) begin
              r_found        <= 1'b1;
              r_result_nonce <= r_nonce;
            end else if (!w_last) begin
              r_nonce <= r_nonce + NONCE_W'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign o_req_valid    = r_req_valid;
  assign o_req_nonce    = r_nonce;
  assign o_busy         = r_busy;
  assign o_done         = r_done;
  assign o_found        = r_found;
  assign o_result_nonce = r_result_nonce;
  assign o_attempts     = r_attempts;
  assign o_state        = r_state;

endmodule

// File: tb/tb_nonce_search_ctrl.sv
// Bench for nonce_search_ctrl: a table-driven hash responder plus a reference model that
// derives the winning nonce and attempt count directly from the hash table and target.
module tb_nonce_search_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       i_start, i_abort, i_req_ready, i_rsp_valid;
  logic [7:0] i_target, i_rsp_hash;
  logic       o_req_valid, o_busy, o_done, o_found;
  logic [3:0] o_req_nonce, o_result_nonce;
  logic [4:0] o_attempts;
  logic [1:0] o_state;

  logic [7:0] tab [16];
  logic [3:0] exp_q [$];
  int         n_checks = 0;
  int         n_fail   = 0;

  nonce_search_ctrl #(.HASH_W(8), .NONCE_W(4), .MAX_NONCE(15)) dut (
    .clk(clk), .rst(rst), .i_start(i_start), .i_abort(i_abort), .i_target(i_target),
    .o_req_valid(o_req_valid), .o_req_nonce(o_req_nonce), .i_req_ready(i_req_ready),
    .i_rsp_valid(i_rsp_valid), .i_rsp_hash(i_rsp_hash), .o_busy(o_busy), .o_done(o_done),
    .o_found(o_found), .o_result_nonce(o_result_nonce), .o_attempts(o_attempts),
    .o_state(o_state)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // One search against the current hash table. abort_at >= 0 aborts while waiting on that nonce.
  task automatic run_search(input logic [7:0] tgt, input int delay, input int hold,
                            input bit rnd_rdy, input bit stray, input int abort_at);
    bit         exp_found = 0;
    logic [3:0] exp_res   = 0;
    int         exp_att   = 16;
    int         n_req;
    int         cyc = 0, cnt = 0, first_acc = -1, hold_left = hold;
    bit         done_seen = 0, aborted = 0;
    bit         prev_valid = 0, prev_ready = 0, prev_rsp = 0;
    logic [3:0] prev_nonce = 0, acc_nonce = 0;

    for (int i = 0; i < 16; i++)
      if (!exp_found && tab[i] < tgt) begin
        exp_found = 1; exp_res = 4'(i); exp_att = i + 1;
      end
    n_req = (abort_at >= 0) ? abort_at + 1 : exp_att;
    exp_q.delete();
    for (int i = 0; i < n_req; i++) exp_q.push_back(4'(i));

    @(negedge clk);
    i_target = tgt; i_start = 1'b1;
    while (!done_seen && !aborted && cyc < 400) begin
      @(negedge clk);
      cyc++;
      i_start = stray ? ($urandom_range(0, 3) == 0) : 1'b0;
      i_abort = 1'b0;
      if (prev_valid && !prev_ready) begin
        check_eq("hold_valid", o_req_valid, 1);
        check_eq("hold_nonce", o_req_nonce, prev_nonce);
      end
      if (prev_valid && prev_ready) begin
        if (exp_q.size() == 0) check_eq("extra_req", 1, 0);
        else check_eq("req_nonce", prev_nonce, exp_q.pop_front());
        acc_nonce = prev_nonce;
        cnt = delay;
        if (first_acc < 0) first_acc = cyc;
      end
      if (o_done) begin
        done_seen = 1;
        check_eq("done_latency", prev_rsp, 1);
        check_eq("found", o_found, exp_found);
        check_eq("result_nonce", o_result_nonce, exp_res);
        check_eq("attempts", o_attempts, exp_att);
      end
      i_rsp_valid = 1'b0;
      i_rsp_hash  = 8'($urandom);
      prev_rsp    = 0;
      if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          i_rsp_valid = 1'b1;
          i_rsp_hash  = tab[acc_nonce];
          prev_rsp    = 1;
          if (int'(acc_nonce) == abort_at) begin
            i_abort = 1'b1; i_rsp_hash = 8'h00; aborted = 1;
          end
        end
      end else if (stray && o_req_valid && $urandom_range(0, 1) == 1) begin
        i_rsp_valid = 1'b1;
        i_rsp_hash  = 8'h00;
      end
      if (hold_left > 0) begin
        i_req_ready = 1'b0; hold_left--;
      end else begin
        i_req_ready = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
      end
      prev_valid = o_req_valid; prev_ready = i_req_ready; prev_nonce = o_req_nonce;
    end

    if (!rnd_rdy) check_eq("first_accept_cycle", first_acc, hold + 2);
    if (aborted) begin
      @(negedge clk);
      i_abort = 1'b0; i_rsp_valid = 1'b0; i_start = 1'b0;
      check_eq("abort_busy", o_busy, 0);
      check_eq("abort_req_valid", o_req_valid, 0);
      check_eq("abort_found", o_found, 0);
      check_eq("abort_attempts", o_attempts, abort_at);
      for (int k = 0; k < 3; k++) begin
        @(negedge clk);
        check_eq("abort_no_done", o_done, 0);
      end
    end else if (!done_seen) begin
      check_eq("timeout", 1, 0);
    end else begin
      i_start = 1'b1;
      @(negedge clk);
      i_start = 1'b0; i_rsp_valid = 1'b0;
      check_eq("post_done_pulse", o_done, 0);
      check_eq("post_done_busy", o_busy, 0);
      check_eq("post_done_req_valid", o_req_valid, 0);
      check_eq("held_found", o_found, exp_found);
      check_eq("held_result", o_result_nonce, exp_res);
      check_eq("held_attempts", o_attempts, exp_att);
    end
    check_eq("all_requested", exp_q.size(), 0);
    i_req_ready = 1'b0;
  endtask

  task automatic reset_mid_search();
    bit         pend = 0, hit = 0;
    logic [3:0] wait_nonce = 0;
    @(negedge clk);
    i_target = 8'h80; i_start = 1'b1; i_req_ready = 1'b1;
    for (int k = 0; k < 60 && !hit; k++) begin
      @(negedge clk);
      i_start = 1'b0; i_rsp_valid = 1'b0;
      if (pend) begin
        if (wait_nonce == 4'd2) hit = 1;
        else begin i_rsp_valid = 1'b1; i_rsp_hash = 8'hFF; pend = 0; end
      end else if (o_req_valid) begin
        pend = 1; wait_nonce = o_req_nonce;
      end
    end
    if (!hit) check_eq("reset_timeout", 1, 0);
    rst = 1'b1; i_req_ready = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    check_eq("rst_req_valid", o_req_valid, 0);
    check_eq("rst_req_nonce", o_req_nonce, 0);
    check_eq("rst_busy", o_busy, 0);
    check_eq("rst_done", o_done, 0);
    check_eq("rst_found", o_found, 0);
    check_eq("rst_result", o_result_nonce, 0);
    check_eq("rst_attempts", o_attempts, 0);
    i_rsp_valid = 1'b1; i_rsp_hash = 8'h00;
    @(negedge clk);
    i_rsp_valid = 1'b0;
    @(negedge clk);
    check_eq("rst_stray_attempts", o_attempts, 0);
    check_eq("rst_stray_found", o_found, 0);
    check_eq("rst_stray_busy", o_busy, 0);
  endtask

  initial begin
    rst = 1'b1; i_start = 0; i_abort = 0; i_target = 0;
    i_req_ready = 0; i_rsp_valid = 0; i_rsp_hash = 0;
    repeat (3) @(negedge clk);
    check_eq("reset_req_valid", o_req_valid, 0);
    check_eq("reset_busy", o_busy, 0);
    check_eq("reset_attempts", o_attempts, 0);
    rst = 1'b0;

    reset_mid_search();

    // Early hit at nonce 2
    for (int i = 0; i < 16; i++) tab[i] = 8'($urandom);
    tab[0] = 8'hF0; tab[1] = 8'h90; tab[2] = 8'h7F;
    run_search(8'h80, 2, 0, 0, 0, -1);

    // Equality is not a hit: full sweep
    for (int i = 0; i < 16; i++) tab[i] = 8'h40;
    run_search(8'h40, 2, 0, 0, 0, -1);

    // Backpressure on the first request
    for (int i = 0; i < 16; i++) tab[i] = 8'hC0;
    tab[4] = 8'h10;
    run_search(8'h80, 1, 5, 0, 0, -1);

    // Abort in WAIT for nonce 3 with a same-cycle zero hash
    for (int i = 0; i < 16; i++) tab[i] = 8'hFF;
    run_search(8'h80, 2, 0, 0, 0, 3);

    // Boundary targets
    for (int i = 0; i < 16; i++) tab[i] = 8'hFF;
    tab[0] = 8'hFE;
    run_search(8'hFF, 1, 0, 0, 0, -1);
    for (int i = 0; i < 16; i++) tab[i] = 8'($urandom);
    tab[15] = 8'h00;
    run_search(8'h00, 1, 0, 0, 0, -1);

    // Randomized searches with random ready, latency, stray start and stray responses
    for (int t = 0; t < 10; t++) begin
      for (int i = 0; i < 16; i++)
        tab[i] = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(0, 255)) : 8'hFF;
      run_search(8'($urandom_range(0, 255)), $urandom_range(1, 3), $urandom_range(0, 3),
                 1, 1, -1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
